// File: rtl/datapath_pkg.sv
// ============================================================================
// Module      : datapath_pkg
// Description : Shared widths and arithmetic select encodings for the divider
//               datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 7;
  localparam int ACC_W      = 8;

  typedef enum logic [1:0] {
    SEL_ADD  = 2'b00,
    SEL_SUB  = 2'b01,
    SEL_PASS = 2'b10,
    SEL_CLR  = 2'b11
  } sel_e;

endpackage

`default_nettype wire

// File: rtl/div_addsub.sv
// ============================================================================
// Module      : div_addsub
// Description : Accumulator arithmetic unit: A + D, A - D, pass or zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_addsub
  import datapath_pkg::*;
(
  input  logic [ACC_W-1:0]     a,
  input  logic [DIVISOR_W-1:0] d,
  input  logic [1:0]           sel,
  output logic [ACC_W-1:0]     result
);

  logic [ACC_W-1:0] w_d_ext;

  // Divisor is unsigned, so it is zero-extended; results wrap modulo 256.
  assign w_d_ext = {1'b0, d};

  always_comb begin
    result = a;
    case (sel_e'(sel))
      SEL_ADD:  result = a + w_d_ext;
      SEL_SUB:  result = a - w_d_ext;
      SEL_PASS: result = a;
      SEL_CLR:  result = '0;
      default:  result = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// ============================================================================
// Module      : datapath
// Description : Register half of an 8-by-7 unsigned shift-subtract divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath
  import datapath_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIVISOR_W-1:0]  divisorin,
  input  logic [DIVIDEND_W-1:0] dividendin,
  input  logic                  load,
  input  logic                  add,
  input  logic                  shift,
  input  logic                  inbit,
  input  logic [1:0]            sel,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  sign
);

  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [ACC_W-1:0]      w_addsub_res;

  div_addsub u_addsub (
    .a      (acc_q),
    .d      (div_q),
    .sel    (sel),
    .result (w_addsub_res)
  );

  // One action per cycle, load beats shift beats add.
  always_comb begin
    div_d = div_q;
    acc_d = acc_q;
    quo_d = quo_q;
    if (load) begin
      div_d = divisorin;
      quo_d = dividendin;
      acc_d = '0;
    end else if (shift) begin
      {acc_d, quo_d} = {acc_q[ACC_W-2:0], quo_q, inbit};
    end else if (add) begin
      acc_d = w_addsub_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
      acc_q <= '0;
      quo_q <= '0;
    end else begin
      div_q <= div_d;
      acc_q <= acc_d;
      quo_q <= quo_d;
    end
  end

  assign remainder = acc_q[DIVISOR_W-1:0];
  assign quotient  = quo_q;
  assign sign      = acc_q[ACC_W-1];

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================================
// Module      : tb_datapath
// Description : Self-checking bench for datapath: directed cases, restoring
//               divisions and randomized control against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] divisorin = '0;
  logic [7:0] dividendin = '0;
  logic       load = 1'b0;
  logic       add = 1'b0;
  logic       shift = 1'b0;
  logic       inbit = 1'b0;
  logic [1:0] sel = '0;
  logic [6:0] remainder;
  logic [7:0] quotient;
  logic       sign;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state held as plain integers.
  int m_a = 0;
  int m_q = 0;
  int m_d = 0;

  datapath u_dut (
    .clk        (clk),
    .reset      (reset),
    .divisorin  (divisorin),
    .dividendin (dividendin),
    .load       (load),
    .add        (add),
    .shift      (shift),
    .inbit      (inbit),
    .sel        (sel),
    .remainder  (remainder),
    .quotient   (quotient),
    .sign       (sign)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit ld, input bit sh,
                            input bit ad, input bit ib, input int sl,
                            input int dvs, input int dvd);
    if (!rst_n) begin
      m_a = 0; m_q = 0; m_d = 0;
    end else if (ld) begin
      m_d = dvs; m_q = dvd; m_a = 0;
    end else if (sh) begin
      m_a = (m_a * 2 + m_q / 128) % 256;
      m_q = (m_q * 2 + ib) % 256;
    end else if (ad) begin
      case (sl)
        0: m_a = (m_a + m_d) % 256;
        1: m_a = (m_a - m_d + 256) % 256;
        2: m_a = m_a;
        default: m_a = 0;
      endcase
    end
  endtask

  // Drive one cycle, advance the model, then sample 10 units after the edge.
  task automatic cycle(input bit rst_n, input bit ld, input bit sh,
                       input bit ad, input bit ib, input int sl,
                       input int dvs, input int dvd);
    reset = rst_n; load = ld; shift = sh; add = ad; inbit = ib;
    sel = 2'(sl); divisorin = 7'(dvs); dividendin = 8'(dvd);
    model_step(rst_n, ld, sh, ad, ib, sl, dvs, dvd);
    @(posedge clk);
    #10;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rem"}, int'(remainder), m_a % 128);
    check({tag, ".quo"}, int'(quotient), m_q);
    check({tag, ".sign"}, int'(sign), m_a / 128);
  endtask

  // Restoring divide: the controller knows each quotient bit up front and
  // uses the sign after the trial subtract to decide whether to restore.
  task automatic restoring_div(input int dvd, input int dvs);
    int qt;
    int b;
    qt = dvd / dvs;
    cycle(1, 1, 0, 0, 0, 0, dvs, dvd);
    for (int i = 7; i >= 0; i--) begin
      b = (qt >> i) & 1;
      cycle(1, 0, 1, 0, b[0], 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 1, 0, 0);
      if (sign) cycle(1, 0, 0, 1, 0, 0, 0, 0);
    end
    check($sformatf("div%0d/%0d.quo", dvd, dvs), int'(quotient), qt);
    check($sformatf("div%0d/%0d.rem", dvd, dvs), int'(remainder), dvd % dvs);
    check($sformatf("div%0d/%0d.sign", dvd, dvs), int'(sign), 0);
  endtask

  initial begin
    // Reset overrides a simultaneous load.
    cycle(0, 1, 1, 1, 1, 0, 7'h55, 8'hAA);
    check("reset.rem", int'(remainder), 0);
    check("reset.quo", int'(quotient), 0);
    check("reset.sign", int'(sign), 0);

    cycle(1, 1, 0, 0, 0, 0, 5, 23);
    check("load.rem", int'(remainder), 0);
    check("load.quo", int'(quotient), 8'h17);
    check("load.sign", int'(sign), 0);

    cycle(1, 0, 1, 0, 0, 0, 0, 0);
    check("shift.quo", int'(quotient), 8'h2E);
    check("shift.rem", int'(remainder), 0);
    check("shift.sign", int'(sign), 0);

    cycle(1, 0, 0, 1, 0, 1, 0, 0);
    check("sub.rem", int'(remainder), 7'h7B);
    check("sub.sign", int'(sign), 1);

    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    check("addback.rem", int'(remainder), 0);
    check("addback.sign", int'(sign), 0);

    restoring_div(23, 5);
    restoring_div(255, 127);

    // All three controls: only the load lands.
    cycle(1, 1, 1, 1, 1, 3, 9, 8'hA5);
    check("prio_load.rem", int'(remainder), 0);
    check("prio_load.quo", int'(quotient), 8'hA5);

    // Shift and add together: only the shift lands.
    cycle(1, 0, 1, 1, 1, 3, 0, 0);
    check("prio_shift.rem", int'(remainder), 1);
    check("prio_shift.quo", int'(quotient), 8'h4B);

    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    check("add.rem", int'(remainder), 10);
    cycle(1, 0, 0, 1, 0, 2, 0, 0);
    check("pass.rem", int'(remainder), 10);
    check("pass.quo", int'(quotient), 8'h4B);
    cycle(1, 0, 0, 1, 0, 3, 0, 0);
    check("clr.rem", int'(remainder), 0);
    check("clr.quo", int'(quotient), 8'h4B);

    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 1, 7'h7F, 8'hFF);
    check("idle.rem", int'(remainder), 9);
    check("idle.quo", int'(quotient), 8'h4B);
    check("idle.sign", int'(sign), 0);

    // Abort part-way through a division.
    cycle(1, 1, 0, 0, 0, 0, 5, 23);
    cycle(1, 0, 1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    check("midreset.rem", int'(remainder), 0);
    check("midreset.quo", int'(quotient), 0);
    check("midreset.sign", int'(sign), 0);

    for (int i = 0; i < 6; i++)
      restoring_div(int'($urandom_range(0, 255)), int'($urandom_range(1, 127)));

    // Randomized controls, checked against the arithmetic model every cycle.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 255)));
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
